// File: rtl/l2_write_buffer.sv
// ---------------------------------------------------------------------------
// l2_write_buffer
//   Posted-store buffer between the dcache L2 port and the L2/memory port.
//   Stores are acknowledged when accepted and drained in the background
//   through a circular FIFO of {addr, data} entries. Loads that hit a
//   buffered store are answered with zero added latency (youngest entry
//   wins). Loads that miss are sent downstream ahead of pending drains.
//
// Optional feature macro: WRITE_BUFFER_COALESCE_EN
//   Defined   : a store to the address of a valid entry that is not in
//               flight overwrites that entry. It is accepted even when the
//               buffer is full.
//   Undefined : every store allocates a new entry.
//
// Ports
//   clk, reset             : rising-edge clock, async active-low reset
//   l2_req_*               : upstream request (held stable until fulfilled)
//   l2_word_to_store       : upstream store data
//   l2_fetched_word        : upstream load data, valid with l2_req_fulfilled
//   l2_req_fulfilled       : upstream completion (combinational)
//   mem_req_*              : downstream request, registered
//   mem_word_to_store      : downstream store data
//   mem_fetched_word       : downstream load data
//   mem_req_fulfilled      : downstream completion (level)
//   buffer_empty           : no entries buffered, none in flight
//   buffer_count           : number of entries, including the in-flight head
// ---------------------------------------------------------------------------
package l2_write_buffer_pkg;
    typedef enum logic [1:0] {
        MEM_NOP   = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10
    } memory_operation_e;
endpackage

module l2_write_buffer
    import l2_write_buffer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [XLEN-1:0]         l2_req_address,
    input  memory_operation_e       l2_req_type,
    input  logic                    l2_req_valid,
    input  logic [XLEN-1:0]         l2_word_to_store,
    output logic [XLEN-1:0]         l2_fetched_word,
    output logic                    l2_req_fulfilled,
    output logic [XLEN-1:0]         mem_req_address,
    output memory_operation_e       mem_req_type,
    output logic                    mem_req_valid,
    output logic [XLEN-1:0]         mem_word_to_store,
    input  logic [XLEN-1:0]         mem_fetched_word,
    input  logic                    mem_req_fulfilled,
    output logic                    buffer_empty,
    output logic [$clog2(DEPTH):0]  buffer_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_LD_WAIT, S_LD_BUSY, S_LD_RESP
    } state_e;

    state_e            r_state;
    logic [XLEN-1:0]   r_addr [DEPTH];
    logic [XLEN-1:0]   r_data [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              r_mem_valid;
    memory_operation_e r_mem_type;
    logic [XLEN-1:0]   r_mem_addr;
    logic [XLEN-1:0]   r_mem_data;
    logic [XLEN-1:0]   r_ld_data;

    logic              w_is_store;
    logic              w_is_load;
    logic              w_is_other;
    logic              w_head_busy;
    logic              w_hit;
    logic [XLEN-1:0]   w_hit_data;
    logic              w_coalesce;
    logic              w_store_acc;
    logic              w_alloc;
    logic              w_retire;
    logic              w_ld_miss;
    logic [XLEN-1:0]   w_head_wdata;
`ifdef WRITE_BUFFER_COALESCE_EN
    logic              w_cmatch;
    logic [PW-1:0]     w_cidx;
`endif

    assign w_is_store  = l2_req_valid && (l2_req_type == MEM_STORE);
    assign w_is_load   = l2_req_valid && (l2_req_type == MEM_LOAD);
    assign w_is_other  = l2_req_valid && !w_is_store && !w_is_load;
    // The head entry is frozen while its store is outstanding downstream.
    assign w_head_busy = r_mem_valid && (r_mem_type == MEM_STORE);

    // Walk entries oldest to youngest so the last match is the youngest.
    always_comb begin
        logic [PW-1:0] v_idx;
        v_idx      = '0;
        w_hit      = 1'b0;
        w_hit_data = '0;
`ifdef WRITE_BUFFER_COALESCE_EN
        w_cmatch   = 1'b0;
        w_cidx     = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            v_idx = r_head + PW'(i);
            if ((CW'(i) < r_count) && (r_addr[v_idx] == l2_req_address)) begin
                w_hit      = 1'b1;
                w_hit_data = r_data[v_idx];
`ifdef WRITE_BUFFER_COALESCE_EN
                if (!(w_head_busy && (v_idx == r_head))) begin
                    w_cmatch = 1'b1;
                    w_cidx   = v_idx;
                end
`endif
            end
        end
    end

`ifdef WRITE_BUFFER_COALESCE_EN
    assign w_coalesce   = w_is_store && w_cmatch;
    // A coalesce into the head on the edge it starts draining must send the new data.
    assign w_head_wdata = (w_coalesce && (w_cidx == r_head)) ? l2_word_to_store
                                                             : r_data[r_head];
`else
    assign w_coalesce   = 1'b0;
    assign w_head_wdata = r_data[r_head];
`endif

    // A full buffer stalls even when the head retires this edge.
    assign w_store_acc = w_is_store && ((r_count < CW'(DEPTH)) || w_coalesce);
    assign w_alloc     = w_store_acc && !w_coalesce;
    assign w_retire    = w_head_busy && mem_req_fulfilled;
    assign w_ld_miss   = w_is_load && !w_hit;

    always_comb begin
        l2_req_fulfilled = 1'b0;
        l2_fetched_word  = '0;
        if (r_state == S_LD_RESP) begin
            l2_req_fulfilled = w_is_load;
            l2_fetched_word  = r_ld_data;
        end else if (w_is_store) begin
            l2_req_fulfilled = w_store_acc;
        end else if (w_is_load) begin
            l2_req_fulfilled = w_hit;
            l2_fetched_word  = w_hit_data;
        end else if (w_is_other) begin
            l2_req_fulfilled = 1'b1;
        end
    end

    // Downstream handshake: mem_req_valid and all mem_req_* fields are
    // registered, held stable until mem_req_fulfilled is seen high on a
    // rising edge, and then mem_req_valid is low for at least one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_mem_valid <= 1'b0;
            r_mem_type  <= MEM_NOP;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_ld_data   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_alloc) begin
                r_addr[r_tail] <= l2_req_address;
                r_data[r_tail] <= l2_word_to_store;
                r_tail         <= r_tail + PW'(1);
            end
`ifdef WRITE_BUFFER_COALESCE_EN
            if (w_coalesce) begin
                r_data[w_cidx] <= l2_word_to_store;
            end
`endif
            if (w_retire) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_alloc, w_retire})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (w_ld_miss) begin
                        r_mem_valid <= 1'b1;
                        r_mem_type  <= MEM_LOAD;
                        r_mem_addr  <= l2_req_address;
                        r_state     <= S_LD_BUSY;
                    end else if (r_count != '0) begin
                        r_mem_valid <= 1'b1;
                        r_mem_type  <= MEM_STORE;
                        r_mem_addr  <= r_addr[r_head];
                        r_mem_data  <= w_head_wdata;
                        r_state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (mem_req_fulfilled) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (w_ld_miss) begin
                        r_state     <= S_LD_WAIT;
                    end
                end
                S_LD_WAIT: begin
                    // Finish the outstanding drain first, then idle one cycle.
                    if (r_mem_valid) begin
                        if (mem_req_fulfilled) begin
                            r_mem_valid <= 1'b0;
                        end
                    end else begin
                        r_mem_valid <= 1'b1;
                        r_mem_type  <= MEM_LOAD;
                        r_mem_addr  <= l2_req_address;
                        r_state     <= S_LD_BUSY;
                    end
                end
                S_LD_BUSY: begin
                    if (mem_req_fulfilled) begin
                        r_ld_data   <= mem_fetched_word;
                        r_mem_valid <= 1'b0;
                        r_state     <= S_LD_RESP;
                    end
                end
                S_LD_RESP: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req_valid     = r_mem_valid;
    assign mem_req_type      = r_mem_type;
    assign mem_req_address   = r_mem_addr;
    assign mem_word_to_store = r_mem_data;
    assign buffer_empty      = (r_count == '0);
    assign buffer_count      = r_count;

endmodule

// File: tb/tb_l2_write_buffer.sv
// ---------------------------------------------------------------------------
// tb_l2_write_buffer
//   Directed bench for l2_write_buffer. Expected downstream transactions go
//   into mem_exp_q and expected load data into exp_q when stimulus is
//   issued; two monitors pop and compare whenever the DUT completes a
//   transaction on either port.
// ---------------------------------------------------------------------------
module tb_l2_write_buffer;
    import l2_write_buffer_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic              clk;
    logic              reset;
    logic [XLEN-1:0]   l2_req_address;
    memory_operation_e l2_req_type;
    logic              l2_req_valid;
    logic [XLEN-1:0]   l2_word_to_store;
    logic [XLEN-1:0]   l2_fetched_word;
    logic              l2_req_fulfilled;
    logic [XLEN-1:0]   mem_req_address;
    memory_operation_e mem_req_type;
    logic              mem_req_valid;
    logic [XLEN-1:0]   mem_word_to_store;
    logic [XLEN-1:0]   mem_fetched_word;
    logic              mem_req_fulfilled;
    logic              buffer_empty;
    logic [2:0]        buffer_count;

    logic              mem_stall;
    logic [XLEN-1:0]   mem_load_value;
    logic [XLEN-1:0]   mem_model [logic [XLEN-1:0]];

    logic [XLEN-1:0]   exp_q[$];
    logic [65:0]       mem_exp_q[$];

    int n_cmp;
    int n_err;
    int mem_txn;
    int cyc;
    int txn_before;

    assign mem_req_fulfilled = mem_req_valid && !mem_stall;
    assign mem_fetched_word  = mem_load_value;

    l2_write_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .l2_req_address    (l2_req_address),
        .l2_req_type       (l2_req_type),
        .l2_req_valid      (l2_req_valid),
        .l2_word_to_store  (l2_word_to_store),
        .l2_fetched_word   (l2_fetched_word),
        .l2_req_fulfilled  (l2_req_fulfilled),
        .mem_req_address   (mem_req_address),
        .mem_req_type      (mem_req_type),
        .mem_req_valid     (mem_req_valid),
        .mem_word_to_store (mem_word_to_store),
        .mem_fetched_word  (mem_fetched_word),
        .mem_req_fulfilled (mem_req_fulfilled),
        .buffer_empty      (buffer_empty),
        .buffer_count      (buffer_count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name, input int n);
        n_cmp++;
        n_err++;
        $display("FAIL %s: no event within %0d cycles (t=%0t)", name, n, $time);
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns just after a rising edge.
    task automatic issue(input memory_operation_e t, input logic [31:0] a,
                         input logic [31:0] d, input int max_cyc, output int n);
        l2_req_type      = t;
        l2_req_address   = a;
        l2_word_to_store = d;
        l2_req_valid     = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (l2_req_fulfilled) break;
            n++;
            if (n > max_cyc) begin
                timeout_fail("issue_timeout", max_cyc);
                break;
            end
        end
        @(posedge clk);
        #1;
        l2_req_valid = 1'b0;
    endtask

    task automatic wait_empty(input int max_cyc);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (buffer_empty && !mem_req_valid) break;
            n++;
            if (n > max_cyc) begin
                timeout_fail("wait_empty", max_cyc);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mem_valid(input int max_cyc);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (mem_req_valid) break;
            n++;
            if (n > max_cyc) begin
                timeout_fail("wait_mem_valid", max_cyc);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitors / scoreboard ----------------
    initial begin : mem_monitor
        logic        gap_chk;
        logic [65:0] e;
        gap_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (gap_chk) begin
                chk("mem_valid_gap", {31'b0, mem_req_valid}, 32'd0);
                gap_chk = 1'b0;
            end
            if (mem_req_valid && mem_req_fulfilled) begin
                mem_txn++;
                if (mem_exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL mem_unexpected: got type %0d addr %h, expected no request",
                             mem_req_type, mem_req_address);
                end else begin
                    e = mem_exp_q.pop_front();
                    chk("mem_type", {30'b0, mem_req_type}, {30'b0, e[65:64]});
                    chk("mem_addr", mem_req_address, e[63:32]);
                    if (e[65:64] == MEM_STORE)
                        chk("mem_data", mem_word_to_store, e[31:0]);
                end
                if (mem_req_type == MEM_STORE)
                    mem_model[mem_req_address] = mem_word_to_store;
                gap_chk = 1'b1;
            end
        end
    end

    initial begin : l2_monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (l2_req_valid && l2_req_fulfilled && l2_req_type == MEM_LOAD) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL l2_unexpected: got load data %h, expected no response",
                             l2_fetched_word);
                end else begin
                    e = exp_q.pop_front();
                    chk("l2_load_data", l2_fetched_word, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        n_cmp            = 0;
        n_err            = 0;
        mem_txn          = 0;
        reset            = 1'b0;
        l2_req_valid     = 1'b0;
        l2_req_type      = MEM_NOP;
        l2_req_address   = '0;
        l2_word_to_store = '0;
        mem_stall        = 1'b0;
        mem_load_value   = 32'hACAB0012;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_fulfilled", {31'b0, l2_req_fulfilled}, 32'd0);
        chk("rst_fetched", l2_fetched_word, 32'd0);
        chk("rst_mem_addr", mem_req_address, 32'd0);
        chk("rst_mem_data", mem_word_to_store, 32'd0);
        chk("rst_empty", {31'b0, buffer_empty}, 32'd1);
        chk("rst_count", {29'b0, buffer_count}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Non-load/store request completes immediately with no effect
        issue(MEM_NOP, 32'h300, 32'h1, 5, cyc);
        chk("nop_lat", cyc, 32'd0);
        chk("nop_count", {29'b0, buffer_count}, 32'd0);

        // Single store, posted then drained
        mem_exp_q.push_back({MEM_STORE, 32'h100, 32'hDEADBEEF});
        issue(MEM_STORE, 32'h100, 32'hDEADBEEF, 5, cyc);
        chk("st_lat", cyc, 32'd0);
        chk("st_count", {29'b0, buffer_count}, 32'd1);
        chk("st_not_empty", {31'b0, buffer_empty}, 32'd0);
        wait_empty(20);
        chk("st_count_drained", {29'b0, buffer_count}, 32'd0);
        chk("mem_0x100", mem_model[32'h100], 32'hDEADBEEF);

        // Fill to DEPTH with downstream stalled, fifth store stalls
        mem_stall = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            a = 32'(i * 4);
            mem_exp_q.push_back({MEM_STORE, a, 32'h1000 + a});
            issue(MEM_STORE, a, 32'h1000 + a, 5, cyc);
            chk("fill_lat", cyc, 32'd0);
        end
        chk("count_full", {29'b0, buffer_count}, 32'd4);
        mem_exp_q.push_back({MEM_STORE, 32'h10, 32'h1010});
        l2_req_type      = MEM_STORE;
        l2_req_address   = 32'h10;
        l2_word_to_store = 32'h1010;
        l2_req_valid     = 1'b1;
        @(negedge clk);
        chk("full_stall", {31'b0, l2_req_fulfilled}, 32'd0);
        @(posedge clk);
        #1;
        mem_stall = 1'b0;
        @(negedge clk);
        chk("full_boundary", {31'b0, l2_req_fulfilled}, 32'd0);
        @(negedge clk);
        chk("accept_after_retire", {31'b0, l2_req_fulfilled}, 32'd1);
        @(posedge clk);
        #1;
        l2_req_valid = 1'b0;
        wait_empty(40);
        chk("mem_0x10", mem_model[32'h10], 32'h1010);

        // Two stores to one address, then a forwarded load
        mem_stall = 1'b1;
`ifndef WRITE_BUFFER_COALESCE_EN
        mem_exp_q.push_back({MEM_STORE, 32'h20, 32'h11});
`endif
        mem_exp_q.push_back({MEM_STORE, 32'h20, 32'h22});
        issue(MEM_STORE, 32'h20, 32'h11, 5, cyc);
        chk("dup1_lat", cyc, 32'd0);
        issue(MEM_STORE, 32'h20, 32'h22, 5, cyc);
        chk("dup2_lat", cyc, 32'd0);
`ifdef WRITE_BUFFER_COALESCE_EN
        chk("count_dup", {29'b0, buffer_count}, 32'd1);
`else
        chk("count_dup", {29'b0, buffer_count}, 32'd2);
`endif
        exp_q.push_back(32'h22);
        issue(MEM_LOAD, 32'h20, 32'h0, 5, cyc);
        chk("fwd_lat", cyc, 32'd0);
        mem_stall = 1'b0;
        wait_empty(30);
        chk("mem_0x20", mem_model[32'h20], 32'h22);

        // Load miss goes downstream ahead of a buffered store
        mem_load_value = 32'hACAB0012;
        mem_exp_q.push_back({MEM_LOAD, 32'h80, 32'h0});
        mem_exp_q.push_back({MEM_STORE, 32'h40, 32'h12345678});
        exp_q.push_back(32'hACAB0012);
        issue(MEM_STORE, 32'h40, 32'h12345678, 5, cyc);
        chk("st40_lat", cyc, 32'd0);
        issue(MEM_LOAD, 32'h80, 32'h0, 10, cyc);
        chk("miss_lat", cyc, 32'd2);
        wait_empty(20);
        chk("mem_0x40", mem_model[32'h40], 32'h12345678);

        // Store to the in-flight head allocates; then a miss waits for the drain
        mem_stall = 1'b1;
        mem_exp_q.push_back({MEM_STORE, 32'h50, 32'h77});
        issue(MEM_STORE, 32'h50, 32'h77, 5, cyc);
        wait_mem_valid(10);
        mem_exp_q.push_back({MEM_LOAD, 32'h90, 32'h0});
        mem_exp_q.push_back({MEM_STORE, 32'h50, 32'h99});
        issue(MEM_STORE, 32'h50, 32'h99, 5, cyc);
        chk("inflight_st_lat", cyc, 32'd0);
        chk("count_inflight", {29'b0, buffer_count}, 32'd2);
        exp_q.push_back(32'h99);
        issue(MEM_LOAD, 32'h50, 32'h0, 5, cyc);
        chk("fwd_young_lat", cyc, 32'd0);
        mem_load_value = 32'h0BADF00D;
        exp_q.push_back(32'h0BADF00D);
        fork
            begin
                repeat (3) @(posedge clk);
                #1;
                mem_stall = 1'b0;
            end
        join_none
        issue(MEM_LOAD, 32'h90, 32'h0, 30, cyc);
        chk("ldwait_lat", cyc, 32'd6);
        chk("count_after_ldwait", {29'b0, buffer_count}, 32'd1);
        wait_empty(20);
        chk("mem_0x50", mem_model[32'h50], 32'h99);

        // Reset in the middle of a drain drops everything
        mem_stall = 1'b1;
        issue(MEM_STORE, 32'hA0, 32'hA0A0, 5, cyc);
        issue(MEM_STORE, 32'hA4, 32'hA4A4, 5, cyc);
        issue(MEM_STORE, 32'hA8, 32'hA8A8, 5, cyc);
        wait_mem_valid(10);
        chk("count_pre_rst", {29'b0, buffer_count}, 32'd3);
        chk("valid_pre_rst", {31'b0, mem_req_valid}, 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst_mem_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("midrst_count", {29'b0, buffer_count}, 32'd0);
        chk("midrst_empty", {31'b0, buffer_empty}, 32'd1);
        txn_before = mem_txn;
        @(posedge clk);
        #1;
        reset     = 1'b1;
        mem_stall = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("no_write_after_rst", mem_txn, txn_before);
        chk("valid_after_rst", {31'b0, mem_req_valid}, 32'd0);

        chk("mem_q_drained", mem_exp_q.size(), 32'd0);
        chk("l2_q_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/l2_write_buffer.md
Name: l2_write_buffer

Overview:
- Posted-store buffer between the dcache L2 port and the L2/main-memory port.
- Stores from the dcache are acknowledged in the same cycle they are accepted, then drained to memory in the background.
- Loads are forwarded from the buffer when the address matches a buffered store; otherwise they go to memory ahead of pending drains.
- Each upstream and downstream port carries a single word per transaction.

Parameters:
XLEN, 32, data/address width in bits
DEPTH, 4, number of buffered store entries (power of two, >=2)

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-low reset
l2_req_address  in  XLEN  word address from dcache
l2_req_type  in  memory_operation_e  LOAD / STORE / other
l2_req_valid  in  1  request valid; held with stable fields until fulfilled
l2_word_to_store  in  XLEN  store data
l2_fetched_word  out  XLEN  load data; valid while l2_req_fulfilled=1 on a LOAD
l2_req_fulfilled  out  1  request completes on a rising edge where valid&&fulfilled
mem_req_address  out  XLEN  downstream address
mem_req_type  out  memory_operation_e  LOAD or STORE
mem_req_valid  out  1  downstream request valid
mem_word_to_store  out  XLEN  downstream store data
mem_fetched_word  in  XLEN  downstream load data; sampled when mem_req_fulfilled=1
mem_req_fulfilled  in  1  downstream completion, level, may be combinational from mem_req_valid
buffer_empty  out  1  no valid entries and no store in flight
buffer_count  out  $clog2(DEPTH)+1  valid entries, including the head in flight

Behaviour:
- Reset (reset=0, async): all entries invalid; count=0; state IDLE; mem_req_valid=0; l2_req_fulfilled=0; l2_fetched_word=0; mem_* data/address=0; buffer_empty=1. Reset mid-transaction drops every buffered and in-flight store.
- Storage: circular FIFO with head and tail pointers; entry = {addr, data}. Pointers wrap modulo DEPTH.
- STORE accept: combinational l2_req_fulfilled=1 when count<DEPTH or the store coalesces. Write takes effect on the same edge. When full and not coalescing, fulfilled=0 and the store stalls until the head retires.
- Full boundary: if the head retires on the same edge that a store arrives at count==DEPTH, the store is still stalled that cycle. It is accepted the next cycle.
- LOAD hit: address equals some valid entry -> combinational fulfilled=1, l2_fetched_word = data of the youngest matching entry. Zero added latency.
- LOAD miss: state LD_WAIT.
  - Waits for any in-flight drain to finish.
  - Issues LOAD (LD_BUSY) with priority over pending drains.
  - On the mem_req_fulfilled edge, captures mem_fetched_word and enters LD_RESP.
  - LD_RESP asserts l2_req_fulfilled for exactly 1 cycle from the captured register, then returns to IDLE.
  - Minimum miss latency is 3 cycles when the buffer is idle.
- Other l2_req_type: fulfilled=1 combinationally with no effect.
- FSM transitions:
  - IDLE -> DRAIN when count>0 and no load miss is pending.
  - IDLE -> LD_BUSY on a load miss.
  - DRAIN -> IDLE on mem_req_fulfilled; on the same edge the head pointer advances and count decrements.
  - LD_WAIT -> LD_BUSY when no drain is in flight.
  - LD_BUSY -> LD_RESP on mem_req_fulfilled.
  - LD_RESP -> IDLE.
- Downstream handshake:
  - mem_req_valid and all fields are registered and held stable until mem_req_fulfilled is sampled high.
  - mem_req_valid is then 0 for at least 1 cycle before the next transaction.
- In-flight protection: the head entry in DRAIN is never modified. A store to its address allocates a new entry, and forwarding returns the newer one.
- Simultaneous events: a store accept and a head retire on the same edge leave count unchanged.

Optional Feature:
WRITE_BUFFER_COALESCE_EN
- Defined: a store whose address matches a valid, non-in-flight entry overwrites that entry's data. No allocation occurs, and it is accepted even when the buffer is full.
- Undefined: every store allocates a new entry. Duplicate addresses may coexist, and forwarding uses the youngest.

Test Plan:
- Reset, then STORE 0x100<-0xDEADBEEF -> fulfilled same cycle, count=1; mem sees STORE 0x100/0xDEADBEEF next cycle; count=0 and buffer_empty=1 after mem ack.
- DEPTH=4, mem_req_fulfilled held 0, stores to 0x0,0x4,0x8,0xC,0x10 -> first 4 fulfilled; 5th stalls (fulfilled=0); accepted the cycle after the 0x0 drain acks.
- STORE 0x20<-0x11, STORE 0x20<-0x22 (drain blocked), LOAD 0x20 -> fulfilled same cycle with 0x22; count=1 with the _EN macro defined, 2 without.
- Buffer holds 0x40, LOAD 0x80 (memory value 0xACAB0012) -> load issued before the 0x40 drain; data 0xACAB0012 returned in LD_RESP; 0x40 drained afterwards.
- Drain of 0x50 in flight, STORE 0x50<-0x99 -> new entry allocated (count=2); memory ends with 0x99 at 0x50.
- Assert reset while DRAIN is active with 3 entries -> mem_req_valid=0 and count=0 immediately, buffer_empty=1; no further memory writes.
